ctrl_pipe: RTL

Parametrised pipelined control unit for the five-stage RISC-V core. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and branch-operand hazards, squashes on redirect, and counts illegal opcodes. It replaces the purely combinational opcode decoder, and the datapath pipeline registers no longer carry control bits.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/ctrl_decoder.sv | 95 +++++++++
 rtl/ctrl_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle carried through the ID/EX, EX/MEM and MEM/WB registers.
package ctrl_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;
  localparam int unsigned AOP_W = 2;
  localparam int unsigned WBS_W = 2;

  localparam logic [OPC_W-1:0] OPC_NOP   = 7'b0000000;
  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;

  localparam logic [AOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [AOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [AOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [AOP_W-1:0] ALUOP_PASSB = 2'b11;

  localparam logic [WBS_W-1:0] WB_ALU = 2'b00;
  localparam logic [WBS_W-1:0] WB_MEM = 2'b01;
  localparam logic [WBS_W-1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [AOP_W-1:0] aluop;
    logic             alusrc;
    logic             branch;
    logic             jump;
    logic             mem_read;
    logic             mem_write;
    logic             regwrite;
    logic [WBS_W-1:0] wb_sel;
    logic [REG_W-1:0] rd;
    logic             illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode decode into a control bundle, plus source-register usage flags.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [REG_W-1:0] rd_i,
  output ctrl_t            ctrl_o,
  output logic             jalr_o,
  output logic             rs1_used_o,
  output logic             rs2_used_o
);

  localparam bit EXT = (EXT_OPS != 32'd0);

  logic writes_rd;

  always_comb begin
    ctrl_o     = CTRL_NOP;
    jalr_o     = 1'b0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    writes_rd  = 1'b0;
    case (opcode_i)
      OPC_R: begin
        ctrl_o.aluop = ALUOP_FUNCT;
        writes_rd    = 1'b1;
        rs1_used_o   = 1'b1;
        rs2_used_o   = 1'b1;
      end
      OPC_I: begin
        ctrl_o.aluop  = ALUOP_ADD;
        ctrl_o.alusrc = 1'b1;
        writes_rd     = 1'b1;
        rs1_used_o    = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.wb_sel   = WB_MEM;
        writes_rd       = 1'b1;
        rs1_used_o      = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.mem_write = 1'b1;
        rs1_used_o       = 1'b1;
        rs2_used_o       = 1'b1;
      end
      OPC_BEQ: begin
        ctrl_o.aluop  = ALUOP_SUB;
        ctrl_o.branch = 1'b1;
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OPC_NOP: ;
      OPC_LUI: begin
        if (EXT) begin
          ctrl_o.aluop  = ALUOP_PASSB;
          ctrl_o.alusrc = 1'b1;
          writes_rd     = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        if (EXT) begin
          ctrl_o.jump   = 1'b1;
          ctrl_o.wb_sel = WB_PC4;
          writes_rd     = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OPC_JALR: begin
        if (EXT) begin
          ctrl_o.jump   = 1'b1;
          ctrl_o.alusrc = 1'b1;
          ctrl_o.wb_sel = WB_PC4;
          writes_rd     = 1'b1;
          rs1_used_o    = 1'b1;
          jalr_o        = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    // rd is only carried for writers so downstream rd compares never see immediate bits
    ctrl_o.regwrite = writes_rd && (rd_i != '0);
    ctrl_o.rd       = ctrl_o.regwrite ? rd_i : '0;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID instruction, carries control to EX/MEM/WB,
// detects load-use and branch-operand hazards, and counts illegal opcodes.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W      = 2,
  parameter int unsigned EXT_OPS      = 1,
  parameter int unsigned BRANCH_IN_ID = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        inst_i,
  input  logic               id_valid_i,
  input  logic               flush_i,
  output logic               id_branch_o,
  output logic               id_jump_o,
  output logic               stall_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic [4:0]         ex_rd_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [4:0]         mem_rd_o,
  output logic               wb_regwrite_o,
  output logic [1:0]         wb_sel_o,
  output logic [4:0]         wb_rd_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   illegal_cnt_o
);

  ctrl_t            dec_c, ex_d, ex_q, mem_q, wb_q;
  logic             dec_jalr_c, rs1_used_c, rs2_used_c;
  logic [REG_W-1:0] rs1_c, rs2_c;
  logic             ex_hit_c, mem_hit_c, load_use_c, br_haz_c, stall_c;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             unused_bits;

  ctrl_decoder #(.EXT_OPS(EXT_OPS)) u_dec (
    .opcode_i   (inst_i[6:0]),
    .rd_i       (inst_i[11:7]),
    .ctrl_o     (dec_c),
    .jalr_o     (dec_jalr_c),
    .rs1_used_o (rs1_used_c),
    .rs2_used_o (rs2_used_c)
  );

  // Hazard terms look only at registered EX/MEM state, so no loop through stall
  always_comb begin
    rs1_c      = inst_i[19:15];
    rs2_c      = inst_i[24:20];
    ex_hit_c   = (rs1_used_c && (rs1_c == ex_q.rd)) || (rs2_used_c && (rs2_c == ex_q.rd));
    mem_hit_c  = (rs1_used_c && (rs1_c == mem_q.rd)) || (rs2_used_c && (rs2_c == mem_q.rd));
    load_use_c = ex_q.mem_read && (ex_q.rd != '0) && ex_hit_c;
    br_haz_c   = (BRANCH_IN_ID != 32'd0) && (dec_c.branch || dec_jalr_c) &&
                 ((ex_q.regwrite && ex_hit_c) ||
                  (mem_q.mem_read && (mem_q.rd != '0) && mem_hit_c));
    stall_c    = id_valid_i && (load_use_c || br_haz_c) && !flush_i;
    ex_d       = (stall_c || flush_i || !id_valid_i) ? CTRL_NOP : dec_c;
    cnt_d      = (ex_q.illegal && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= CTRL_NOP;
      mem_q <= CTRL_NOP;
      wb_q  <= CTRL_NOP;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  assign stall_o       = stall_c;
  assign id_branch_o   = id_valid_i && dec_c.branch && !stall_c && !flush_i;
  assign id_jump_o     = id_valid_i && dec_c.jump && !stall_c && !flush_i;
  assign ex_aluop_o    = ALUOP_W'(ex_q.aluop);
  assign ex_alusrc_o   = ex_q.alusrc;
  assign ex_rd_o       = ex_q.rd;
  assign illegal_o     = ex_q.illegal;
  assign illegal_cnt_o = cnt_q;
  assign mem_read_o    = mem_q.mem_read;
  assign mem_write_o   = mem_q.mem_write;
  assign mem_rd_o      = mem_q.rd;
  assign wb_regwrite_o = wb_q.regwrite;
  assign wb_sel_o      = wb_q.wb_sel;
  assign wb_rd_o       = wb_q.rd;

  assign unused_bits = ^{wb_q.aluop, wb_q.alusrc, wb_q.branch, wb_q.jump, wb_q.mem_read,
                         wb_q.mem_write, wb_q.illegal, inst_i[31:25], inst_i[14:12]};

endmodule
